alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Initiator side of the ALU operation interface. Accepts decoded operations from the control path with a valid/ready handshake and drives the ALU's op/a/b inputs. For single-cycle operations it captures the combinational result; for divide it waits on the ALU's busy handshake. It returns the result with the destination register tag on a valid/ready writeback port, and flags divides that time out.

Parameters:
REG_ADDR_W, 3, width of destination register tag
DIV_START_TIMEOUT, 4, max cycles in DIV_START waiting for alu_busy to rise
DIV_TIMEOUT, 64, max cycles in DIV_WAIT waiting for alu_busy to fall
CNT_W, 16, width of completed-operation counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  1  operation request valid
req_ready  out  1  sequencer can accept a request
req_op  in  6  ALU opcode
req_a  in  8  operand A
req_b  in  8  operand B
req_rd  in  REG_ADDR_W  destination register tag
alu_op  out  6  opcode to ALU
alu_a  out  8  operand A to ALU
alu_b  out  8  operand B to ALU
alu_result  in  8  ALU result
alu_busy  in  1  ALU multicycle (divide) busy
wb_valid  out  1  writeback valid
wb_ready  in  1  writeback consumer ready
wb_data  out  8  result
wb_rd  out  REG_ADDR_W  destination tag
wb_err  out  1  result invalid, divide timed out; qualified by wb_valid
ops_done  out  CNT_W  completed writebacks, wraps

Behaviour:
- Opcode constants:
  - DIV = 6'b000011.
  - NOP = 6'b111111 (ALU produces 0).
  - Every other code is single-cycle and is passed through unchecked.
- Reset (async, rst=1):
  - state=IDLE, req_ready=1, wb_valid=0, wb_err=0, wb_data=0, wb_rd=0, ops_done=0.
  - alu_op=NOP, alu_a=0, alu_b=0, timers=0.
  - Reset mid-operation abandons the operation; no writeback is produced.
- alu_op/alu_a/alu_b are driven from captured registers. alu_op=NOP in IDLE and WB.
- States:
  - IDLE:
    - req_ready=1.
    - On req_valid: capture op/a/b/rd. Go to EXEC if op!=DIV, else DIV_START.
  - EXEC:
    - alu_op=captured op.
    - Next edge: wb_data<=alu_result, wb_err<=0, go to WB.
    - wb_valid is high 2 edges after the accept edge.
  - DIV_START:
    - alu_op=DIV; timer counts cycles.
    - alu_busy=1: clear timer, go to DIV_WAIT.
    - Timer reaches DIV_START_TIMEOUT with alu_busy=0: wb_data<=0, wb_err<=1, go to WB.
  - DIV_WAIT:
    - alu_op=DIV.
    - alu_busy=0 sampled: wb_data<=alu_result, wb_err<=0, go to WB.
    - Timer reaches DIV_TIMEOUT with alu_busy=1: wb_data<=0, wb_err<=1, go to WB.
  - WB:
    - wb_valid=1; wb_data/wb_rd/wb_err are held stable while wb_ready=0.
    - On wb_ready: ops_done+1 (wraps at 2^CNT_W), go to IDLE, req_ready=1 next cycle.
- req_ready=0 in every state except IDLE; requests are never dropped.
- Only one operation is in flight; no pipelining.
- Timer compare:
  - Timeout fires when the count equals the parameter value.
  - A busy transition sampled on the same edge as the timeout wins: no error.
- No buffering; operand widths pass through unmodified.

Test Plan:
- Reset with rst pulsed mid-DIV_WAIT -> all outputs at reset values, alu_op=NOP, no wb_valid afterwards.
- ADD req_op=000000, a=8'd25, b=8'd17, rd=3, wb_ready=1 -> wb_valid 2 edges after accept, wb_data=42, wb_rd=3, wb_err=0, ops_done=1.
- DIV a=100, b=7; ALU model raises busy 1 cycle after op, drops it 10 cycles later with result 14 -> wb_data=14, wb_err=0; alu_op=DIV throughout, then NOP.
- DIV with ALU model never asserting busy -> wb_err=1, wb_data=0 after DIV_START_TIMEOUT=4 cycles; also busy held for 100 cycles -> wb_err=1 after 64.
- Backpressure: XOR a=8'hF0, b=8'h3C, wb_ready=0 for 5 cycles -> wb_valid stays high, wb_data=8'hCC stable, req_ready=0; a second request is held until the first completes.
- Back-to-back requests with req_valid held high, 3 ops -> each accepted only in IDLE, ops_done=3; preset counter at 16'hFFFF -> wraps to 0.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: request, ALU and writeback signals of the ALU operation sequencer
interface alu_op_sequencer_if #(
    parameter int REG_ADDR_W = 3,
    parameter int CNT_W      = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic [5:0]            req_op;
    logic [7:0]            req_a;
    logic [7:0]            req_b;
    logic [REG_ADDR_W-1:0] req_rd;
    logic [5:0]            alu_op;
    logic [7:0]            alu_a;
    logic [7:0]            alu_b;
    logic [7:0]            alu_result;
    logic                  alu_busy;
    logic                  wb_valid;
    logic                  wb_ready;
    logic [7:0]            wb_data;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  wb_err;
    logic [CNT_W-1:0]      ops_done;
    modport master (
        input  req_valid, req_op, req_a, req_b, req_rd, alu_result, alu_busy, wb_ready,
        output req_ready, alu_op, alu_a, alu_b, wb_valid, wb_data, wb_rd, wb_err, ops_done
    );
    modport slave (
        output req_valid, req_op, req_a, req_b, req_rd, alu_result, alu_busy, wb_ready,
        input  req_ready, alu_op, alu_a, alu_b, wb_valid, wb_data, wb_rd, wb_err, ops_done
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one operation at a time to the ALU, waits out divides with
// start/finish timeouts, and returns the result with its register tag on a writeback port
module alu_op_sequencer #(
    parameter int REG_ADDR_W        = 3,
    parameter int DIV_START_TIMEOUT = 4,
    parameter int DIV_TIMEOUT       = 64,
    parameter int CNT_W             = 16
) (
    input logic clk,
    input logic rst,
    alu_op_sequencer_if.master bus
);
    localparam logic [5:0] DIV = 6'b000011;
    localparam logic [5:0] NOP = 6'b111111;
    localparam int TMAX = DIV_TIMEOUT > DIV_START_TIMEOUT ? DIV_TIMEOUT : DIV_START_TIMEOUT;
    localparam int TW = $clog2(TMAX + 1);

    typedef enum logic [2:0] {IDLE, EXEC, DIV_START, DIV_WAIT, WB} state_t;

    state_t                state, state_nx;
    logic [5:0]            op_r;
    logic [7:0]            a_r, b_r, data_r, wb_d;
    logic [REG_ADDR_W-1:0] rd_r;
    logic                  err_r, wb_e, wb_ld;
    logic [TW-1:0]         timer, timer_nx, tick;
    logic [CNT_W-1:0]      cnt;

    assign tick = timer + 1'b1;

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        wb_ld    = 1'b0;
        wb_d     = bus.alu_result;
        wb_e     = 1'b0;
        case (state)
            IDLE:      if (bus.req_valid) state_nx = bus.req_op == DIV ? DIV_START : EXEC;
            EXEC: begin
                state_nx = WB;
                wb_ld    = 1'b1;
            end
            // a busy edge seen on the timeout cycle still counts as a live divide
            DIV_START: begin
                timer_nx = bus.alu_busy || tick == TW'(DIV_START_TIMEOUT) ? '0 : tick;
                state_nx = bus.alu_busy ? DIV_WAIT : tick == TW'(DIV_START_TIMEOUT) ? WB : DIV_START;
                wb_ld    = !bus.alu_busy && tick == TW'(DIV_START_TIMEOUT);
                wb_d     = 8'd0;
                wb_e     = 1'b1;
            end
            DIV_WAIT: begin
                timer_nx = !bus.alu_busy || tick == TW'(DIV_TIMEOUT) ? '0 : tick;
                state_nx = !bus.alu_busy || tick == TW'(DIV_TIMEOUT) ? WB : DIV_WAIT;
                wb_ld    = !bus.alu_busy || tick == TW'(DIV_TIMEOUT);
                wb_d     = bus.alu_busy ? 8'd0 : bus.alu_result;
                wb_e     = bus.alu_busy;
            end
            WB:        if (bus.wb_ready) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            timer  <= '0;
            op_r   <= NOP;
            a_r    <= 8'd0;
            b_r    <= 8'd0;
            rd_r   <= '0;
            data_r <= 8'd0;
            err_r  <= 1'b0;
            cnt    <= '0;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
            if (state == IDLE && bus.req_valid) begin
                op_r <= bus.req_op;
                a_r  <= bus.req_a;
                b_r  <= bus.req_b;
                rd_r <= bus.req_rd;
            end
            if (wb_ld) begin
                data_r <= wb_d;
                err_r  <= wb_e;
            end
            if (state == WB && bus.wb_ready) cnt <= cnt + 1'b1;
        end
    end

    assign bus.req_ready = state == IDLE;
    assign bus.wb_valid  = state == WB;
    assign bus.alu_op    = state == EXEC || state == DIV_START || state == DIV_WAIT ? op_r : NOP;
    assign bus.alu_a     = a_r;
    assign bus.alu_b     = b_r;
    assign bus.wb_data   = data_r;
    assign bus.wb_rd     = rd_r;
    assign bus.wb_err    = err_r;
    assign bus.ops_done  = cnt;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: randomized and directed operations against a transaction-level model
// of the sequencer, with an ALU emulation whose divide busy timing is scripted per operation
module tb_alu_op_sequencer;
    localparam int CW = 4;
    localparam int START_TO = 4;
    localparam int DIV_TO = 64;
    localparam logic [5:0] DIV = 6'b000011;
    localparam logic [5:0] NOP = 6'b111111;
    localparam logic [5:0] ADD = 6'b000000;
    localparam logic [5:0] XOR = 6'b000101;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_ops = 0;

    logic [5:0] t_op [64];
    logic [7:0] t_a [64];
    logic [7:0] t_b [64];
    logic [2:0] t_rd [64];
    int         t_rise [64];
    int         t_hold [64];
    int         t_stall [64];

    alu_op_sequencer_if #(.REG_ADDR_W(3), .CNT_W(CW)) bus ();

    alu_op_sequencer #(
        .REG_ADDR_W(3), .DIV_START_TIMEOUT(START_TO), .DIV_TIMEOUT(DIV_TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            6'd0:    return a + b;
            6'd1:    return a - b;
            6'd2:    return a & b;
            6'd4:    return a | b;
            6'd5:    return a ^ b;
            DIV:     return b == 8'd0 ? 8'hFF : a / b;
            NOP:     return 8'd0;
            default: return a + b + {2'b00, op};
        endcase
    endfunction

    assign bus.alu_result = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // expected writeback and the number of cycles from accept until the writeback edge
    function automatic void model(input int i, output logic [7:0] d, output bit e, output int kd);
        if (t_op[i] != DIV) begin
            d = alu_f(t_op[i], t_a[i], t_b[i]); e = 0; kd = 1;
        end else if (t_rise[i] >= START_TO) begin
            d = 8'd0; e = 1; kd = START_TO;
        end else if (t_hold[i] > DIV_TO) begin
            d = 8'd0; e = 1; kd = t_rise[i] + 1 + DIV_TO;
        end else begin
            d = alu_f(DIV, t_a[i], t_b[i]); e = 0; kd = t_rise[i] + t_hold[i] + 1;
        end
    endfunction

    task automatic set_op(input int i, input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] rd, input int rise, input int hold, input int stall);
        t_op[i] = op; t_a[i] = a; t_b[i] = b; t_rd[i] = rd;
        t_rise[i] = rise; t_hold[i] = hold; t_stall[i] = stall;
    endtask

    task automatic drive_req(input int i);
        bus.req_valid = 1'b1;
        bus.req_op = t_op[i]; bus.req_a = t_a[i]; bus.req_b = t_b[i]; bus.req_rd = t_rd[i];
    endtask

    task automatic run_op(input int i, input bit b2b, input int n);
        logic [7:0] ed;
        bit ee;
        int kd, w;
        drive_req(i);
        w = 0;
        while (!bus.req_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!bus.req_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (b2b && i + 1 < n) drive_req(i + 1);
        else bus.req_valid = 1'b0;
        model(i, ed, ee, kd);
        for (int k = 1; k <= kd; k++) begin
            if (t_op[i] == DIV) bus.alu_busy = k > t_rise[i] && k <= t_rise[i] + t_hold[i];
            check("alu_op_busy", bus.alu_op, t_op[i]);
            check("ready_busy", bus.req_ready, 0);
            check("wb_valid_early", bus.wb_valid, 0);
            @(negedge clk);
        end
        bus.alu_busy = 1'b0;
        for (int s = 0; s <= t_stall[i]; s++) begin
            bus.wb_ready = s == t_stall[i];
            check("wb_valid", bus.wb_valid, 1);
            check("wb_data", bus.wb_data, ed);
            check("wb_err", bus.wb_err, ee);
            check("wb_rd", bus.wb_rd, t_rd[i]);
            check("alu_op_wb", bus.alu_op, NOP);
            check("ready_wb", bus.req_ready, 0);
            @(negedge clk);
        end
        bus.wb_ready = 1'b0;
        exp_ops++;
        check("wb_valid_done", bus.wb_valid, 0);
        check("ops_done", bus.ops_done, exp_ops % (1 << CW));
        check("ready_idle", bus.req_ready, 1);
    endtask

    task automatic run_seq(input int n, input bit b2b);
        for (int i = 0; i < n; i++) run_op(i, b2b, n);
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_wb_valid", bus.wb_valid, 0);
        check("rst_wb_err", bus.wb_err, 0);
        check("rst_wb_data", bus.wb_data, 0);
        check("rst_wb_rd", bus.wb_rd, 0);
        check("rst_ops_done", bus.ops_done, 0);
        check("rst_alu_op", bus.alu_op, NOP);
        check("rst_alu_a", bus.alu_a, 0);
        check("rst_alu_b", bus.alu_b, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus.req_valid = 1'b0; bus.req_op = 6'd0; bus.req_a = 8'd0; bus.req_b = 8'd0; bus.req_rd = 3'd0;
        bus.alu_busy = 1'b0; bus.wb_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        @(negedge clk);

        set_op(0, ADD, 8'd25, 8'd17, 3'd3, 0, 0, 0);
        run_seq(1, 0);
        set_op(0, DIV, 8'd100, 8'd7, 3'd1, 1, 10, 0);
        run_seq(1, 0);
        set_op(0, DIV, 8'd90, 8'd9, 3'd2, 99, 1, 0);
        set_op(1, DIV, 8'd90, 8'd9, 3'd4, 3, 2, 1);
        set_op(2, DIV, 8'd77, 8'd5, 3'd5, 1, 100, 0);
        set_op(3, DIV, 8'd77, 8'd5, 3'd6, 0, 64, 0);
        set_op(4, DIV, 8'd77, 8'd5, 3'd7, 2, 65, 0);
        run_seq(5, 0);
        set_op(0, XOR, 8'hF0, 8'h3C, 3'd6, 0, 0, 5);
        set_op(1, ADD, 8'd1, 8'd2, 3'd2, 0, 0, 0);
        run_seq(2, 1);
        set_op(0, 6'd1, 8'd9, 8'd4, 3'd1, 0, 0, 0);
        set_op(1, DIV, 8'd200, 8'd0, 3'd2, 0, 3, 2);
        set_op(2, NOP, 8'd5, 8'd6, 3'd3, 0, 0, 1);
        run_seq(3, 1);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 10; i++) begin
                int pick;
                logic [5:0] op;
                pick = $urandom_range(0, 7);
                op = pick == 0 ? 6'd0 : pick == 1 ? 6'd1 : pick == 2 ? 6'd2 : pick == 3 ? 6'd4 :
                     pick == 4 ? 6'd5 : pick == 7 ? 6'($urandom) : DIV;
                set_op(i, op, 8'($urandom), 8'($urandom), 3'($urandom), $urandom_range(0, 5),
                       $urandom_range(0, 9) == 0 ? $urandom_range(62, 67) : $urandom_range(1, 12),
                       $urandom_range(0, 3));
            end
            run_seq(10, r[0]);
        end

        bus.req_valid = 1'b1; bus.req_op = DIV; bus.req_a = 8'd50; bus.req_b = 8'd5; bus.req_rd = 3'd5;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.alu_busy = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_rst_alu_op", bus.alu_op, DIV);
        #2 rst = 1'b1;
        #1 check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        bus.alu_busy = 1'b0;
        exp_ops = 0;
        repeat (5) begin
            @(negedge clk);
            check("post_rst_wb_valid", bus.wb_valid, 0);
            check("post_rst_ready", bus.req_ready, 1);
        end
        set_op(0, ADD, 8'd3, 8'd4, 3'd1, 0, 0, 0);
        run_seq(1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
